reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the register file's single write port (RDaddr/RDdata/RegWrite) between two writers.
//  Writer 0 is the pipeline WB stage; writer 1 is a long-latency unit (mul/div).
//  Writer 0 has fixed priority. A starvation counter forces a writer-1 grant after MAX_WAIT lost cycles.
//  A registered output stage drives the register file ports directly.
// PARAMETERS
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
//  MAX_WAIT  3   lost arbitration cycles before writer 1 is forced through (>=1)
//  DROP_R0   1   1: accept but suppress writes to address 0
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  wb_valid_i   in   1       writer 0 has a write
//  wb_ready_o   out  1       writer 0 write accepted this cycle
//  wb_addr_i    in   ADDR_W  writer 0 destination
//  wb_data_i    in   DATA_W  writer 0 data
//  lu_valid_i   in   1       writer 1 has a write (held until accepted)
//  lu_ready_o   out  1       writer 1 write accepted this cycle
//  lu_addr_i    in   ADDR_W  writer 1 destination
//  lu_data_i    in   DATA_W  writer 1 data
//  stall_o      out  1       pipeline must hold WB: wb_valid_i & force
//  RegWrite_o   out  1       to register file RegWrite_i
//  RDaddr_o     out  ADDR_W  to register file RDaddr_i
//  RDdata_o     out  DATA_W  to register file RDdata_i
// BEHAVIOUR
//  - force = lu_valid_i & (wait_cnt == MAX_WAIT). Combinational.
//  - g0 = wb_valid_i & ~force. g1 = lu_valid_i & (~wb_valid_i | force). At most one grant per cycle.
//  - wb_ready_o = ~force; lu_ready_o = g1. Both outputs are combinational.
//  - A transfer happens when valid & ready in the same cycle. An unaccepted request stays valid with stable addr/data.
//  - wait_cnt (width clog2(MAX_WAIT+1)):
//    - cleared when g1 or ~lu_valid_i;
//    - else increments, saturating at MAX_WAIT.
//  - Output stage, registered on posedge clk_i, 1-cycle latency from accept to RegWrite_o:
//    - on g0|g1: RDaddr_o/RDdata_o <= the winner's addr/data;
//      RegWrite_o <= 1, except 0 when DROP_R0 and the winner's addr == 0;
//    - on no grant: RegWrite_o <= 0; RDaddr_o/RDdata_o hold their values.
//  - An accepted write to r0 with DROP_R0=1 still asserts the ready, so the writer retires it. No register write occurs.
//  - Simultaneous wb and lu with wait_cnt < MAX_WAIT: wb wins; lu waits; wait_cnt+1.
//  - Forced cycle: lu wins; wb_ready_o=0; stall_o=1 if wb_valid_i; wait_cnt -> 0 next cycle.
//  - Back-to-back lu with no wb: one write per cycle, no bubbles.
//  - Same-address writes in consecutive cycles land in grant order (last grant wins).
//  - Reset (async assert, any time, including mid-transfer):
//    - RegWrite_o=0, RDaddr_o=0, RDdata_o=0, wait_cnt=0 immediately;
//    - the in-flight registered write is discarded.
//  - Reset deassertion: outputs take effect from the first rising edge after release.
//  - No X propagation: with both valids low, the grants are 0 regardless of the addr/data inputs.
// TESTING
//  1. wb-only: wb_valid=1, addr=5, data=0xDEADBEEF -> wb_ready=1 same cycle; next edge RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF.
//  2. Contention, MAX_WAIT=3:
//     - wb and lu valid every cycle (lu addr 7) -> wb wins cycles 0-2;
//     - cycle 3: force, lu_ready=1, stall_o=1, RDaddr_o=7 next cycle;
//     - cycle 4: wb wins again.
//  3. r0 drop: lu write addr=0, data=0x1234 -> lu_ready=1; next cycle RegWrite_o=0.
//     With DROP_R0=0 -> RegWrite_o=1, RDaddr_o=0.
//  4. lu-only burst: four lu writes addr 1..4 -> RegWrite_o high 4 consecutive cycles with addrs 1,2,3,4; wait_cnt stays 0.
//  5. Reset mid-op: assert rst_i low between edges while RegWrite_o=1 -> RegWrite_o=0 immediately.
//     Release with lu pending -> lu granted on first edge; wait_cnt restarts at 0.
//  6. Integration: write addr 9 = 0x55 via lu while the pipeline reads addr 9 the same cycle as RegWrite_o=1 -> register file bypass returns 0x55.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the register file's single write port between two writers:
//   writer 0 (wb_*) : pipeline WB stage, fixed priority
//   writer 1 (lu_*) : long-latency unit (mul/div), holds its request until
//                     accepted; forced through after MAX_WAIT lost cycles
// The winning write is registered and drives the register file directly,
// so RegWrite_o rises one clock after the accepting cycle.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-low reset
//   wb_valid_i   writer 0 has a write
//   wb_ready_o   writer 0 write accepted this cycle (combinational)
//   wb_addr_i    writer 0 destination register
//   wb_data_i    writer 0 data
//   lu_valid_i   writer 1 has a write
//   lu_ready_o   writer 1 write accepted this cycle (combinational)
//   lu_addr_i    writer 1 destination register
//   lu_data_i    writer 1 data
//   stall_o      pipeline must hold WB (writer 0 lost to a forced writer 1)
//   RegWrite_o   register file write enable
//   RDaddr_o     register file write address
//   RDdata_o     register file write data
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter bit DROP_R0  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Number of consecutive cycles writer 1 has been pending without a grant.
  logic [CNT_W-1:0]  wait_cnt;

  logic              force_lu;
  logic              grant_wb;
  logic              grant_lu;
  logic              grant_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_drop;

  // Writer 1 has waited long enough: it takes this cycle regardless of wb.
  assign force_lu  = lu_valid_i & (wait_cnt == MAX_CNT);

  // Both grants are gated by their own valid, so idle inputs never grant
  // even if addr/data are undriven.
  assign grant_wb  = wb_valid_i & ~force_lu;
  assign grant_lu  = lu_valid_i & (~wb_valid_i | force_lu);
  assign grant_any = grant_wb | grant_lu;

  assign wb_ready_o = ~force_lu;
  assign lu_ready_o = grant_lu;
  assign stall_o    = wb_valid_i & force_lu;

  // Winner select. The write to r0 is still accepted (ready asserted) so the
  // writer retires it; only the register file enable is suppressed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    win_addr = wb_addr_i;
    win_data = wb_data_i;
    if (grant_lu) begin
      win_addr = lu_addr_i;
      win_data = lu_data_i;
    end
    win_drop = DROP_R0 && (win_addr == '0);
  end

  // Starvation counter: cleared on a writer 1 grant or when it has no request,
  // otherwise counts lost cycles and saturates at MAX_WAIT.
  // NOTE: async reset sits in the sensitivity list; sequential state uses
  // non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
    end else if (grant_lu || !lu_valid_i) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered write port. Address/data hold between writes; only the enable
  // drops. Reset discards any write captured but not yet presented.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (grant_any) begin
      RegWrite_o <= ~win_drop;
      RDaddr_o   <= win_addr;
      RDdata_o   <= win_data;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed bench for reg_write_arbiter (MAX_WAIT=3). Two instances share the
// same stimulus: u_a with DROP_R0=1 and u_b with DROP_R0=0. A small register
// file model with write-through bypass sits on u_a's write port.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              wb_valid_i = 1'b0;
  logic [ADDR_W-1:0] wb_addr_i  = '0;
  logic [DATA_W-1:0] wb_data_i  = '0;
  logic              lu_valid_i = 1'b0;
  logic [ADDR_W-1:0] lu_addr_i  = '0;
  logic [DATA_W-1:0] lu_data_i  = '0;

  logic              a_wb_ready, a_lu_ready, a_stall, a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_wb_ready, b_lu_ready, b_stall, b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  reg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3), .DROP_R0(1'b1)) u_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(a_wb_ready), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(a_lu_ready), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
    .stall_o(a_stall), .RegWrite_o(a_we), .RDaddr_o(a_addr), .RDdata_o(a_data)
  );

  reg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3), .DROP_R0(1'b0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(b_wb_ready), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(b_lu_ready), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
    .stall_o(b_stall), .RegWrite_o(b_we), .RDaddr_o(b_addr), .RDdata_o(b_data)
  );

  // Register file model: r0 hardwired to zero, read bypasses a same-cycle write.
  logic [DATA_W-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk_i) if (a_we && a_addr != '0) rf[a_addr] <= a_data;

  function automatic logic [DATA_W-1:0] rf_read(input logic [ADDR_W-1:0] ra);
    if (ra == '0) return '0;
    if (a_we && a_addr == ra) return a_data;
    return rf[ra];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    @(negedge clk_i);
    wb_valid_i = wv; wb_addr_i = wa; wb_data_i = wd;
    lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // ---------------- reset state, idle inputs with junk addr/data ---------
    wb_addr_i = 5'd17; wb_data_i = 32'hA5A5_5A5A;
    lu_addr_i = 5'd22; lu_data_i = 32'h0F0F_F0F0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_we",    a_we, 0);
    check("rst_addr",  a_addr, 0);
    check("rst_data",  a_data, 0);
    check("rst_cnt",   u_a.wait_cnt, 0);
    check("idle_lurdy", a_lu_ready, 0);
    check("idle_wbrdy", a_wb_ready, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    after_edge();
    check("idle_we", a_we, 0);

    // ---------------- 1. wb-only ---------------------------------------------
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0);
    check("t1_wbrdy", a_wb_ready, 1);
    check("t1_lurdy", a_lu_ready, 0);
    check("t1_stall", a_stall, 0);
    after_edge();
    check("t1_we",   a_we, 1);
    check("t1_addr", a_addr, 5);
    check("t1_data", a_data, 32'hDEAD_BEEF);
    drive(0, 5'd6, 32'h1111_1111, 0, '0, '0);
    after_edge();
    check("t1_we_off",   a_we, 0);
    check("t1_addr_hold", a_addr, 5);
    check("t1_data_hold", a_data, 32'hDEAD_BEEF);

    // ---------------- 2. contention, forced grant on cycle 3 ----------------
    for (int c = 0; c < 5; c++) begin
      drive(1, 5'(10 + c), 32'h1000 + c, 1, 5'd7, 32'h77);
      check($sformatf("t2_wbrdy_c%0d", c), a_wb_ready, (c == 3) ? 0 : 1);
      check($sformatf("t2_lurdy_c%0d", c), a_lu_ready, (c == 3) ? 1 : 0);
      check($sformatf("t2_stall_c%0d", c), a_stall,    (c == 3) ? 1 : 0);
      after_edge();
      check($sformatf("t2_we_c%0d", c),   a_we, 1);
      check($sformatf("t2_addr_c%0d", c), a_addr, (c == 3) ? 7 : 10 + c);
      check($sformatf("t2_data_c%0d", c), a_data, (c == 3) ? 32'h77 : 32'h1000 + c);
      check($sformatf("t2_cnt_c%0d", c),  u_a.wait_cnt, (c < 3) ? c + 1 : (c == 3) ? 0 : 1);
    end
    drive(0, '0, '0, 0, '0, '0);
    after_edge();
    check("t2_cnt_clear", u_a.wait_cnt, 0);

    // ---------------- 3. r0 write, dropped vs. kept -------------------------
    drive(0, '0, '0, 1, 5'd0, 32'h1234);
    check("t3_lurdy_a", a_lu_ready, 1);
    check("t3_lurdy_b", b_lu_ready, 1);
    after_edge();
    check("t3_we_a",   a_we, 0);
    check("t3_we_b",   b_we, 1);
    check("t3_addr_b", b_addr, 0);
    check("t3_data_b", b_data, 32'h1234);
    check("t3_rf_r0",  rf_read(5'd0), 0);

    // ---------------- 4. lu-only burst, no bubbles ---------------------------
    for (int i = 1; i <= 4; i++) begin
      drive(0, '0, '0, 1, 5'(i), 32'h100 + i);
      check($sformatf("t4_lurdy_%0d", i), a_lu_ready, 1);
      after_edge();
      check($sformatf("t4_we_%0d", i),   a_we, 1);
      check($sformatf("t4_addr_%0d", i), a_addr, i);
      check($sformatf("t4_data_%0d", i), a_data, 32'h100 + i);
      check($sformatf("t4_cnt_%0d", i),  u_a.wait_cnt, 0);
    end
    drive(0, '0, '0, 0, '0, '0);
    after_edge();
    check("t4_we_end", a_we, 0);
    check("t4_rf_r3",  rf_read(5'd3), 32'h103);

    // ---------------- 5. reset mid-operation ---------------------------------
    drive(1, 5'd3, 32'h33, 1, 5'd12, 32'hC);
    after_edge();
    check("t5_we_pre",  a_we, 1);
    check("t5_addr_pre", a_addr, 3);
    check("t5_cnt_pre", u_a.wait_cnt, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t5_we_rst",   a_we, 0);
    check("t5_addr_rst", a_addr, 0);
    check("t5_data_rst", a_data, 0);
    check("t5_cnt_rst",  u_a.wait_cnt, 0);
    drive(0, '0, '0, 1, 5'd12, 32'hC);
    after_edge();
    check("t5_we_inrst", a_we, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("t5_lurdy_rel", a_lu_ready, 1);
    after_edge();
    check("t5_we_rel",   a_we, 1);
    check("t5_addr_rel", a_addr, 12);
    check("t5_data_rel", a_data, 32'hC);
    check("t5_cnt_rel",  u_a.wait_cnt, 0);

    // ---------------- 6. same-cycle read of a just-written register ----------
    drive(0, '0, '0, 1, 5'd9, 32'h55);
    check("t6_rf_before", rf_read(5'd9), 0);
    after_edge();
    check("t6_bypass", rf_read(5'd9), 32'h55);
    drive(0, '0, '0, 0, '0, '0);
    after_edge();
    check("t6_stored", rf_read(5'd9), 32'h55);

    // ---------------- same-address back-to-back: last grant wins ------------
    drive(1, 5'd20, 32'hAAAA, 0, '0, '0);
    drive(0, '0, '0, 1, 5'd20, 32'hBBBB);
    after_edge();
    drive(0, '0, '0, 0, '0, '0);
    after_edge();
    check("t7_last_wins", rf_read(5'd20), 32'hBBBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
